// File: rtl/mul_sequencer.sv
// Shift-add multiplier sequencer for MUL: stalls the PC while stepping through the multiplier bits,
// then pulses Done for one cycle with the low product on Product.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            mcand_q <= A;
            mplr_q  <= B;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Start dropping mid-operation abandons the MUL; the partial acc is left as-is.
          if (!Start) begin
            state_q <= IDLE;
          end else begin
            if (mplr_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
            if ((mplr_q >> 1) == '0 || cnt_q == LAST_STEP) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Start also gates the BUSY term so an abort releases the PC in the same cycle.
  assign Stall   = RST & Start & ((state_q == IDLE) | (state_q == BUSY));
  assign Done    = (state_q == DONE);
  assign Product = acc_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed table, random MULs against an arithmetic model,
// plus hand-written abort and asynchronous reset sequences.
module tb_mul_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Stall;
  logic        Done;
  logic [31:0] Product;

  int checks   = 0;
  int failures = 0;

  mul_sequencer #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Stall  (Stall),
    .Done   (Done),
    .Product(Product)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          scramble;
    bit          keep_start;
    logic [31:0] exp_prod;
    int          exp_done;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Cycles are counted from the IDLE cycle in which Start is first seen.
  function automatic int ref_k(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    return full[31:0];
  endfunction

  // Entered just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                         input bit keep_start, input logic [31:0] exp_prod, input int exp_done,
                         input string nm);
    int          dc;
    int          sc;
    logic [31:0] got;
    dc    = -1;
    sc    = 0;
    got   = 'x;
    Start = 1'b1;
    A     = a;
    B     = b;
    for (int c = 0; c < 40 && dc < 0; c++) begin
      @(negedge CLK);
      if (Stall) sc++;
      if (Done) begin
        dc  = c;
        got = Product;
        if (!keep_start) Start = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (scramble) begin
        A = $urandom;
        B = $urandom;
      end
    end
    chk({nm, "_done_cycle"}, dc, exp_done);
    chk({nm, "_stall_cycles"}, sc, exp_done);
    chk({nm, "_product"}, got, exp_prod);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1234, 2,  "early_b1"};
    vecs[1] = '{32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 2,  "early_b0"};
    vecs[2] = '{32'h0000_0003, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 33, "full_len"};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0000_0002, 33, "signed"};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 18, "overflow"};
    vecs[5] = '{32'h0000_0006, 32'h0000_0003, 1'b1, 1'b1, 32'd18,        3,  "b2b_first"};
    vecs[6] = '{32'h0000_0002, 32'h0000_0009, 1'b1, 1'b0, 32'd18,        5,  "b2b_second"};

    // Reset held with Start asserted: outputs stay quiet.
    RST   = 1'b0;
    Start = 1'b1;
    A     = 32'd5;
    B     = 32'd7;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_stall", Stall, 0);
    chk("reset_done", Done, 0);
    chk("reset_product", Product, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    run_mul(32'd5, 32'd7, 1'b0, 1'b0, 32'd35, 4, "post_reset");

    foreach (vecs[i])
      run_mul(vecs[i].a, vecs[i].b, vecs[i].scramble, vecs[i].keep_start,
              vecs[i].exp_prod, vecs[i].exp_done, vecs[i].name);

    // Abort: Start drops in the second BUSY cycle.
    Start = 1'b1;
    A     = 32'h55;
    B     = 32'hFFFF;
    @(posedge CLK); #1;
    A = 32'd0;
    B = 32'd0;
    @(posedge CLK); #1;
    chk("abort_stall_before", Stall, 1);
    Start = 1'b0;
    #1;
    chk("abort_stall_same_cycle", Stall, 0);
    chk("abort_product_at_drop", Product, 32'h55);
    @(posedge CLK); #1;
    chk("abort_idle_stall", Stall, 0);
    chk("abort_idle_done", Done, 0);
    chk("abort_product_kept", Product, 32'h55);
    @(posedge CLK); #1;
    chk("abort_no_done", Done, 0);
    chk("abort_product_still", Product, 32'h55);

    // Asynchronous reset pulse in the middle of BUSY.
    Start = 1'b1;
    A     = 32'hFF;
    B     = 32'hFFFF;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("busy_before_reset_stall", Stall, 1);
    chk("busy_before_reset_product", Product, 32'h2FD);
    RST = 1'b0;
    #1;
    chk("async_busy_stall", Stall, 0);
    chk("async_busy_done", Done, 0);
    chk("async_busy_product", Product, 0);
    Start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("after_busy_reset_done", Done, 0);
    chk("after_busy_reset_stall", Stall, 0);

    // Asynchronous reset during the DONE cycle suppresses the pulse at once.
    Start = 1'b1;
    A     = 32'h77;
    B     = 32'h1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("done_before_reset", Done, 1);
    chk("done_before_reset_product", Product, 32'h77);
    RST = 1'b0;
    #1;
    chk("async_done_done", Done, 0);
    chk("async_done_product", Product, 0);
    Start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Random MULs against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      bit          scr;
      bit          keep;
      ra   = $urandom;
      rb   = $urandom >> $urandom_range(0, 31);
      scr  = 1'($urandom_range(0, 1));
      keep = (n != 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_mul(ra, rb, scr, keep, ref_prod(ra, rb), ref_k(rb) + 1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
